// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for both sides of pipe_skid_reg.
// slave = the stage itself, master = the surrounding producer/consumer.
interface pipe_skid_reg_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic stage: registered in_ready breaks the ready path, 1 word/cycle.
// Optional synchronous drop of held words via `define PIPE_SKID_FLUSH_EN (adds flush port).
module pipe_skid_reg #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic       clk,
    input  logic       reset,
`ifdef PIPE_SKID_FLUSH_EN
    input  logic       flush,
`endif
    pipe_skid_reg_if.slave bus,
    output logic [1:0] level
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             out_valid_q;
    logic             accept;
    logic             emit;
    logic             drop;

`ifdef PIPE_SKID_FLUSH_EN
    assign drop = flush;
`else
    assign drop = 1'b0;
`endif

    // Ready is a function of registered state only, so no comb path from out_ready.
    assign bus.in_ready  = (state != FULL) & ~reset;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;

    assign accept = bus.in_valid & bus.in_ready;
    assign emit   = out_valid_q & bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            level       <= 2'd0;
            out_valid_q <= 1'b0;
            main_q      <= RESET_VALUE;
            skid_q      <= RESET_VALUE;
        end else if (drop) begin
            // Entry contents are kept; only occupancy is cleared.
            state       <= EMPTY;
            level       <= 2'd0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q      <= bus.in_data;
                        state       <= ONE;
                        level       <= 2'd1;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_q <= bus.in_data;
                    end else if (accept) begin
                        skid_q <= bus.in_data;
                        state  <= FULL;
                        level  <= 2'd2;
                    end else if (emit) begin
                        state       <= EMPTY;
                        level       <= 2'd0;
                        out_valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (emit) begin
                        main_q <= skid_q;
                        state  <= ONE;
                        level  <= 2'd1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    level       <= 2'd0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg (flush scenario under PIPE_SKID_FLUSH_EN).
module tb_pipe_skid_reg;
    localparam int W = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] level;
`ifdef PIPE_SKID_FLUSH_EN
    logic       flush = 1'b0;
`endif
    int n_chk = 0;
    int n_fail = 0;

    pipe_skid_reg_if #(.WIDTH(W)) bus ();

    pipe_skid_reg #(.WIDTH(W), .RESET_VALUE('0)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef PIPE_SKID_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus.slave),
        .level (level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic ov, input logic [1:0] lv,
                           input logic [W-1:0] d, input logic rdy);
        n_chk++;
        if (bus.out_valid !== ov || level !== lv || bus.out_data !== d || bus.in_ready !== rdy) begin
            n_fail++;
            $display("FAIL %s got ov=%b lvl=%0d data=%h rdy=%b exp ov=%b lvl=%0d data=%h rdy=%b",
                     name, bus.out_valid, level, bus.out_data, bus.in_ready, ov, lv, d, rdy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'hDEAD; bus.out_ready = 1'b0;
        #1;
        n_chk++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready got=%b exp=0", bus.in_ready);
        end
        step(); step();
        n_chk++;
        if (bus.out_valid !== 1'b0 || level !== 2'd0) begin
            n_fail++; $display("FAIL reset_hold got ov=%b lvl=%0d exp ov=0 lvl=0", bus.out_valid, level);
        end
        bus.in_valid = 1'b0;
        reset = 1'b0;
        step();
        chk_out("reset_idle", 1'b0, 2'd0, 32'h0, 1'b1);
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 32'h11; step();
        chk_out("stream_11", 1'b1, 2'd1, 32'h11, 1'b1);
        bus.in_data = 32'h22; step();
        chk_out("stream_22", 1'b1, 2'd1, 32'h22, 1'b1);
        bus.in_data = 32'h33; step();
        chk_out("stream_33", 1'b1, 2'd1, 32'h33, 1'b1);
        bus.in_valid = 1'b0; step();
        chk_out("stream_drain", 1'b0, 2'd0, 32'h33, 1'b1);
    endtask

    task automatic test_full();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'hA; step();
        chk_out("full_a", 1'b1, 2'd1, 32'hA, 1'b1);
        bus.in_data = 32'hB; step();
        chk_out("full_ab", 1'b1, 2'd2, 32'hA, 1'b0);
        bus.in_data = 32'hE; step();
        chk_out("full_hold", 1'b1, 2'd2, 32'hA, 1'b0);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; step();
        chk_out("full_pop_a", 1'b1, 2'd1, 32'hB, 1'b1);
        step();
        chk_out("full_pop_b", 1'b0, 2'd0, 32'hB, 1'b1);
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'h5; step();
        chk_out("b2b_load5", 1'b1, 2'd1, 32'h5, 1'b1);
        bus.in_data = 32'h6; bus.out_ready = 1'b1;
        #1;
        chk_out("b2b_emit5", 1'b1, 2'd1, 32'h5, 1'b1);
        step();
        chk_out("b2b_6", 1'b1, 2'd1, 32'h6, 1'b1);
        bus.in_valid = 1'b0; step();
        chk_out("b2b_drain", 1'b0, 2'd0, 32'h6, 1'b1);
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'hC; step();
        bus.in_data = 32'hD; step();
        chk_out("rmid_full", 1'b1, 2'd2, 32'hC, 1'b0);
        bus.in_valid = 1'b0; reset = 1'b1; step();
        chk_out("rmid_reset", 1'b0, 2'd0, 32'h0, 1'b0);
        reset = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("rmid_noemit", 1'b0, 2'd0, 32'h0, 1'b1);
        end
    endtask

`ifdef PIPE_SKID_FLUSH_EN
    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'h1; step();
        bus.in_data = 32'h2; step();
        chk_out("flush_full", 1'b1, 2'd2, 32'h1, 1'b0);
        bus.in_valid = 1'b0; flush = 1'b1; step();
        chk_out("flush_empty", 1'b0, 2'd0, 32'h1, 1'b1);
        flush = 1'b0; bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 32'h3; step();
        chk_out("flush_next3", 1'b1, 2'd1, 32'h3, 1'b1);
        bus.in_valid = 1'b0; step();
        chk_out("flush_drain", 1'b0, 2'd0, 32'h3, 1'b1);
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_stream();
        test_full();
        test_back_to_back();
        test_reset_mid();
`ifdef PIPE_SKID_FLUSH_EN
        test_flush();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Two-entry elastic pipeline stage with a valid/ready handshake on both sides.
- Sits directly upstream of an enable-gated datapath register: out_valid & out_ready forms that register's enable, and out_data forms its d.
- Breaks the combinational ready path between stages while sustaining 1 transfer/cycle.
- Output data resets to a parameterised value, matching the datapath register convention.

Parameters:
WIDTH, 32, data width in bits
RESET_VALUE, 0, value loaded into both data entries on reset

Ports:
clk  input  1  clock, positive edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream presents in_data
in_ready  output  1  stage can accept a word this cycle
in_data  input  WIDTH  upstream data
out_valid  output  1  out_data holds a valid word
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  WIDTH  head word
level  output  2  occupancy: 0, 1 or 2
flush  input  1  (only with PIPE_SKID_FLUSH_EN) drop all held words

Behaviour:
- Definitions: accept = in_valid & in_ready; emit = out_valid & out_ready.
- Storage: main entry (drives out_data) and skid entry.
- State machine: EMPTY (level 0), ONE (level 1), FULL (level 2).
- Reset (reset=1 at posedge):
  - state EMPTY, out_valid 0, level 0.
  - main = skid = RESET_VALUE, so out_data = RESET_VALUE.
  - in_ready is forced 0 combinationally while reset is high; in_valid is ignored.
- Reset mid-operation: all held words are discarded without emission. Reset has priority over flush and over every transfer.
- Output and ready decode:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL) & !reset.
  - in_ready depends only on state and reset, never on out_ready or in_valid.
- Transitions, evaluated at posedge when reset=0:
  - EMPTY: accept -> ONE, main <= in_data. Otherwise stay EMPTY.
  - ONE, accept & emit -> ONE, main <= in_data.
  - ONE, accept & !emit -> FULL, skid <= in_data; main unchanged.
  - ONE, !accept & emit -> EMPTY.
  - ONE, neither -> ONE.
  - FULL: accept is impossible. emit -> ONE, main <= skid. Otherwise stay FULL.
- Latency and throughput:
  - A word accepted at edge N appears on out_data with out_valid=1 after edge N.
  - Continuous in_valid=1, out_ready=1 sustains 1 word/cycle and never enters FULL.
- Ordering: strict FIFO; no word is dropped or duplicated except by reset or flush.
- Stability:
  - While out_valid=1 and out_ready=0, out_data and out_valid hold constant.
  - In EMPTY, out_data holds the last value (not X); consumers must qualify it with out_valid.
  - out_ready is legal to toggle freely; in_valid may drop without a transfer.
- Simultaneous accept & emit in ONE: main is overwritten with the new word; level stays 1.
- level is registered and equals the state encoding.

Optional Feature:
Macro: PIPE_SKID_FLUSH_EN
- Defined:
  - Adds the flush input.
  - flush=1 at posedge (reset=0) -> next state EMPTY, level 0, out_valid 0.
  - A word presented with accept in the same cycle is discarded.
  - An emit in the same cycle still counts as delivered, since out_valid was 1.
  - main and skid contents are retained, not cleared.
  - in_ready is unaffected by flush in that cycle.
- Not defined:
  - No flush port exists.
  - Behaviour is identical to flush tied to 0.

Test Plan:
- Reset then idle -> out_valid=0, level=0, out_data=RESET_VALUE (0), in_ready=1 the cycle after reset drops; in_ready=0 while reset=1.
- Stream 0x11,0x22,0x33 with out_ready=1 -> each word appears 1 cycle after accept, in order; level stays 1; in_ready stays 1.
- Send 0xA, 0xB with out_ready=0 -> level 2, in_ready=0, out_data=0xA held. Raise out_ready -> 0xA, then 0xB emitted; level 2->1->0.
- In ONE holding 0x5, assert in_valid with 0x6 and out_ready=1 in the same cycle -> 0x5 emitted, then out_data=0x6, level 1.
- FULL (0xC,0xD), assert reset for 1 cycle -> level 0, out_valid 0, out_data=RESET_VALUE; no 0xC/0xD emitted afterwards.
- With PIPE_SKID_FLUSH_EN: FULL (0x1,0x2), pulse flush with in_valid=0 -> level 0, out_valid 0; next in 0x3 -> out_data 0x3 after 1 cycle.
